// File: rtl/mem_access_stage.sv
// Memory access stage: passes ALU results to write-back, runs RAM loads/stores.
// Optional abort of stuck RAM transfers is enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage
`ifdef MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] DataAddress,
    input  logic [15:0] DataIn,
    input  logic        ReadMem,
    input  logic        WriteMem,
    input  logic [1:0]  quarter,
    input  logic        write,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_req,
    output logic        ram_we,
    input  logic [15:0] ram_rdata,
    input  logic        ram_ack,
    output logic        stall,
    output logic [15:0] wb_data,
    output logic [1:0]  wb_quarter,
    output logic        wb_write,
    output logic        mem_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state;
    state_t      nState;
    logic [15:0] nAddr;
    logic [15:0] nWdata;
    logic [15:0] nWbData;
    logic [1:0]  nWbQuarter;
    logic        nReq;
    logic        nWe;
    logic        nStall;
    logic        nWbWrite;
    logic [1:0]  capQuarter;
    logic [1:0]  nCapQuarter;
    logic        capWrite;
    logic        nCapWrite;
    logic        capStore;
    logic        nCapStore;

`ifdef MEM_TIMEOUT_EN
    localparam int CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt;
    logic [CntW-1:0] nCnt;
    logic            nMemErr;
`else
    assign mem_err = 1'b0;
`endif

    // Next-state and next-output logic; every output is taken from a register
    always_comb begin
        nState      = state;
        nAddr       = ram_addr;
        nWdata      = ram_wdata;
        nReq        = ram_req;
        nWe         = ram_we;
        nStall      = stall;
        nWbData     = wb_data;
        nWbQuarter  = wb_quarter;
        nWbWrite    = wb_write;
        nCapQuarter = capQuarter;
        nCapWrite   = capWrite;
        nCapStore   = capStore;
`ifdef MEM_TIMEOUT_EN
        nCnt        = cnt;
        nMemErr     = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (ReadMem || WriteMem) begin
                    // A combined read+write request is executed as a store
                    nState      = BUSY;
                    nAddr       = DataAddress;
                    nWdata      = DataIn;
                    nReq        = 1'b1;
                    nWe         = WriteMem;
                    nStall      = 1'b1;
                    nWbWrite    = 1'b0;
                    nCapQuarter = quarter;
                    nCapWrite   = write;
                    nCapStore   = WriteMem;
`ifdef MEM_TIMEOUT_EN
                    nCnt        = '0;
`endif
                end else begin
                    nWbData    = DataAddress;
                    nWbQuarter = quarter;
                    nWbWrite   = write;
                end
            end
            BUSY: begin
                if (ram_ack) begin
                    nState     = IDLE;
                    nReq       = 1'b0;
                    nWe        = 1'b0;
                    nStall     = 1'b0;
                    nWbQuarter = capQuarter;
                    if (capStore) begin
                        nWbWrite = 1'b0;
                    end else begin
                        nWbData  = ram_rdata;
                        nWbWrite = capWrite;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt == CntMax) begin
                    nState   = IDLE;
                    nReq     = 1'b0;
                    nWe      = 1'b0;
                    nStall   = 1'b0;
                    nWbWrite = 1'b0;
                    nMemErr  = 1'b1;
                end else begin
                    nCnt = cnt + CntW'(1);
                end
`endif
            end
            default: nState = IDLE;
        endcase
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_req    <= 1'b0;
            ram_we     <= 1'b0;
            stall      <= 1'b0;
            wb_data    <= '0;
            wb_quarter <= '0;
            wb_write   <= 1'b0;
            capQuarter <= '0;
            capWrite   <= 1'b0;
            capStore   <= 1'b0;
        end else begin
            state      <= nState;
            ram_addr   <= nAddr;
            ram_wdata  <= nWdata;
            ram_req    <= nReq;
            ram_we     <= nWe;
            stall      <= nStall;
            wb_data    <= nWbData;
            wb_quarter <= nWbQuarter;
            wb_write   <= nWbWrite;
            capQuarter <= nCapQuarter;
            capWrite   <= nCapWrite;
            capStore   <= nCapStore;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Busy-cycle counter and one-cycle abort pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            mem_err <= 1'b0;
        end else begin
            cnt     <= nCnt;
            mem_err <= nMemErr;
        end
    end
`endif

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, max BUSY cycles without ram_ack before abort (timeout build only).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: DataAddress  in  16  memory address, or ALU result for non-memory ops.
REQ-005 SHALL have port: DataIn  in  16  store data.
REQ-006 SHALL have ports: ReadMem, WriteMem  in  1  each  load/store request.
REQ-007 SHALL have ports: quarter  in  2  destination register select; write  in  1  regfile write enable.
REQ-008 SHALL have ports: ram_addr, ram_wdata  out  16  each  RAM address and store data.
REQ-009 SHALL have ports: ram_req, ram_we  out  1  each  RAM request and write strobe; ram_rdata  in  16; ram_ack  in  1  RAM completion.
REQ-010 SHALL have port: stall  out  1  holds upstream stages while high.
REQ-011 SHALL have ports: wb_data  out  16; wb_quarter  out  2; wb_write  out  1  registered write-back outputs.
REQ-012 SHALL have port: mem_err  out  1  timeout abort pulse.

Function
REQ-013 SHALL implement FSM states IDLE and BUSY; all outputs registered.
REQ-014 IDLE, ReadMem=WriteMem=0 at posedge: SHALL load wb_data=DataAddress, wb_quarter=quarter, wb_write=write; stay IDLE (1-cycle latency).
REQ-015 IDLE, ReadMem|WriteMem=1 at posedge: SHALL capture address, data, quarter, write, op type; enter BUSY; set ram_req=1, stall=1, ram_we=WriteMem, wb_write=0.
REQ-016 ReadMem and WriteMem both high SHALL be executed as a store; the read is dropped.
REQ-017 In BUSY, ram_addr, ram_wdata, ram_we and ram_req SHALL stay stable until ram_ack is sampled high; upstream inputs SHALL be ignored.
REQ-018 ram_ack high in BUSY: load -> wb_data=ram_rdata, wb_write=captured write; store -> wb_write=0, wb_data unchanged; wb_quarter=captured quarter; ram_req, ram_we, stall -> 0; next state IDLE.
REQ-019 Minimum memory-op latency SHALL be 2 posedges (issue, ack next cycle); no new op accepted in the ack cycle, only on the following edge.
REQ-020 ram_ack high while IDLE SHALL be ignored.
REQ-021 wb_write SHALL be 0 every cycle stall is high (bubble).

Reset
REQ-022 rst_n low SHALL immediately force IDLE and ram_req=0, ram_we=0, stall=0, wb_write=0, mem_err=0, ram_addr=0, ram_wdata=0, wb_data=0, wb_quarter=0, timeout counter=0, including mid-BUSY.
REQ-023 After rst_n release, first posedge SHALL be evaluated as IDLE.

Configuration
REQ-024 Macro MEM_TIMEOUT_EN defined: BUSY counter SHALL count from 0 and reset on entry; counter reaching TIMEOUT_CYCLES-1 without ack SHALL drop ram_req/ram_we/stall, go IDLE, pulse mem_err=1 one cycle, keep wb_write=0.
REQ-025 MEM_TIMEOUT_EN undefined: no counter; BUSY SHALL wait indefinitely; mem_err SHALL be tied 0.

Verification
REQ-026 ALU op: DataAddress=16'h1234, quarter=2, write=1 -> next edge wb_data=16'h1234, wb_quarter=2, wb_write=1, stall=0.
REQ-027 Load from 16'h0040, ack after 3 cycles, ram_rdata=16'hBEEF -> ram_req/stall high 3 cycles, then wb_data=16'hBEEF, wb_write=1.
REQ-028 Store 16'h00AA to 16'h0010 with ReadMem=1 too -> ram_we=1, ram_wdata=16'h00AA, wb_write=0 throughout.
REQ-029 rst_n low 2 cycles into a load -> ram_req, stall drop immediately; outputs zero; later ack ignored.
REQ-030 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> ram_req high 4 cycles, then mem_err pulses 1 cycle, state IDLE.
